// File: rtl/clock_set_controller_pkg.sv
// clock_set_controller_pkg: state encoding, digit indices and BCD digit helpers
package clock_set_controller_pkg;
   typedef enum logic [1:0] {
      ST_EDIT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;
   localparam logic [1:0] D_S1  = 2'd0;
   localparam logic [1:0] D_S10 = 2'd1;
   localparam logic [1:0] D_M1  = 2'd2;
   localparam logic [1:0] D_M10 = 2'd3;
   localparam logic [15:0] DIGIT_LIM = {4'd5, 4'd9, 4'd5, 4'd9};
   function automatic logic [3:0] dig(input logic [15:0] v, input logic [1:0] idx);
      return v[{idx, 2'b00} +: 4];
   endfunction
   function automatic logic [3:0] digit_inc(input logic [3:0] v, input logic [1:0] idx);
      return (v == dig(DIGIT_LIM, idx)) ? 4'd0 : v + 4'd1;
   endfunction
   function automatic logic [3:0] digit_dec(input logic [3:0] v, input logic [1:0] idx);
      return (v == 4'd0) ? dig(DIGIT_LIM, idx) : v - 4'd1;
   endfunction
endpackage

// File: rtl/mmss_bcd_decrement.sv
// mmss_bcd_decrement: MM:SS BCD value minus one second, with borrow chain S1->S10->M1->M10
module mmss_bcd_decrement
   import clock_set_controller_pkg::*;
(
   input  logic [15:0] bcd_in,
   output logic [15:0] bcd_out,
   output logic        is_zero_next
);
   logic b_s10, b_m1, b_m10;
   assign b_s10 = dig(bcd_in, D_S1) == 4'd0;
   assign b_m1  = b_s10 && dig(bcd_in, D_S10) == 4'd0;
   assign b_m10 = b_m1 && dig(bcd_in, D_M1) == 4'd0;
   assign bcd_out = {
      b_m10 ? digit_dec(dig(bcd_in, D_M10), D_M10) : dig(bcd_in, D_M10),
      b_m1  ? digit_dec(dig(bcd_in, D_M1), D_M1)   : dig(bcd_in, D_M1),
      b_s10 ? digit_dec(dig(bcd_in, D_S10), D_S10) : dig(bcd_in, D_S10),
      digit_dec(dig(bcd_in, D_S1), D_S1)
   };
   assign is_zero_next = bcd_out == 16'h0000;
endmodule

// File: rtl/clock_set_controller.sv
// clock_set_controller: countdown MM:SS mode controller (edit/run/pause/done)
// with per-digit edit blinking and whole-display flash when expired.
module clock_set_controller
   import clock_set_controller_pkg::*;
#(
   parameter int BLINK_DIV = 25_000_000,
   parameter int BLINK_W   = 25
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        tick_1hz,
   input  logic        sel_pulse,
   input  logic        inc_pulse,
   input  logic        go_pulse,
   output logic [15:0] digits,
   output logic [1:0]  sel_digit,
   output logic [3:0]  blank,
   output logic        running,
   output logic        expired
);
   state_t              state_q, state_d;
   logic [15:0]         digits_q, digits_d, dec_val;
   logic [1:0]          sel_q, sel_d;
   logic [BLINK_W-1:0]  blink_cnt_q, blink_cnt_d;
   logic                blink_q, blink_d, dec_zero, wrap;
   mmss_bcd_decrement u_dec (
      .bcd_in      (digits_q),
      .bcd_out     (dec_val),
      .is_zero_next(dec_zero)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_EDIT;
         digits_q    <= '0;
         sel_q       <= D_S1;
         blink_cnt_q <= '0;
         blink_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         digits_q    <= digits_d;
         sel_q       <= sel_d;
         blink_cnt_q <= blink_cnt_d;
         blink_q     <= blink_d;
      end
   end
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_EDIT:  state_d = (go_pulse && digits_q != 16'h0000) ? ST_RUN : ST_EDIT;
         ST_RUN:   state_d = (tick_1hz && dec_zero) ? ST_DONE : go_pulse ? ST_PAUSE : ST_RUN;
         ST_PAUSE: state_d = go_pulse ? ST_RUN : sel_pulse ? ST_EDIT : ST_PAUSE;
         default:  state_d = go_pulse ? ST_EDIT : ST_DONE;
      endcase
   end
   // The increment uses the old selection, so a coincident sel_pulse advances afterwards.
   always_comb begin
      digits_d = digits_q;
      sel_d    = sel_q;
      if (state_q == ST_EDIT) begin
         if (inc_pulse) digits_d[{sel_q, 2'b00} +: 4] = digit_inc(dig(digits_q, sel_q), sel_q);
         if (sel_pulse) sel_d = sel_q + 2'd1;
      end else if (state_q == ST_RUN && tick_1hz) begin
         digits_d = dec_val;
      end else if (state_q == ST_DONE && go_pulse) begin
         digits_d = '0;
         sel_d    = D_S1;
      end
      wrap        = blink_cnt_q == BLINK_W'(BLINK_DIV - 1);
      blink_cnt_d = (sel_pulse || wrap) ? '0 : blink_cnt_q + BLINK_W'(1);
      blink_d     = !sel_pulse && (blink_q ^ wrap);
   end
   always_comb begin
      digits    = digits_q;
      sel_digit = sel_q;
      running   = state_q == ST_RUN;
      expired   = state_q == ST_DONE;
      blank     = (state_q == ST_EDIT) ? ({3'b000, blink_q} << sel_q) :
                  (state_q == ST_DONE) ? {4{blink_q}} : 4'b0000;
   end
endmodule

// File: tb/tb_clock_set_controller.sv
// tb_clock_set_controller: directed plus random stimulus against a seconds-based
// reference model of the countdown controller, checked after every clock.
module tb_clock_set_controller;
   logic        clk = 1'b0, rst = 1'b0, tick_1hz = 1'b0;
   logic        sel_pulse = 1'b0, inc_pulse = 1'b0, go_pulse = 1'b0;
   logic [15:0] digits;
   logic [1:0]  sel_digit;
   logic [3:0]  blank;
   logic        running, expired;
   int n_assert = 0, n_fail = 0;
   typedef enum {M_EDIT, M_RUN, M_PAUSE, M_DONE} mode_t;
   mode_t mode = M_EDIT;
   int d[4];
   int sel = 0, blink_n = 0;
   always #5 clk = ~clk;
   clock_set_controller #(.BLINK_DIV(4), .BLINK_W(3)) dut (
      .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .sel_pulse(sel_pulse),
      .inc_pulse(inc_pulse), .go_pulse(go_pulse), .digits(digits),
      .sel_digit(sel_digit), .blank(blank), .running(running), .expired(expired)
   );
   function automatic int secs();
      return (d[3] * 10 + d[2]) * 60 + d[1] * 10 + d[0];
   endfunction
   task automatic set_secs(input int t);
      d[3] = (t / 60) / 10;
      d[2] = (t / 60) % 10;
      d[1] = (t % 60) / 10;
      d[0] = (t % 60) % 10;
   endtask
   task automatic model(input bit r, input bit s, input bit i, input bit g, input bit t);
      bit go_ok;
      if (r) begin
         mode = M_EDIT;
         d = '{0, 0, 0, 0};
         sel = 0;
         blink_n = 0;
         return;
      end
      blink_n = s ? 0 : blink_n + 1;
      case (mode)
         M_EDIT: begin
            go_ok = g && secs() != 0;
            if (i) d[sel] = (d[sel] + 1) % ((sel % 2 == 1) ? 6 : 10);
            if (s) sel = (sel + 1) % 4;
            if (go_ok) mode = M_RUN;
         end
         M_RUN: begin
            if (t) set_secs(secs() - 1);
            if (t && secs() == 0) mode = M_DONE;
            else if (g) mode = M_PAUSE;
         end
         M_PAUSE: begin
            if (g) mode = M_RUN;
            else if (s) mode = M_EDIT;
         end
         M_DONE: begin
            if (g) begin
               mode = M_EDIT;
               sel = 0;
               d = '{0, 0, 0, 0};
            end
         end
      endcase
   endtask
   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic check_all();
      int ph;
      logic [3:0] exp_blank;
      ph = (blink_n / 4) % 2;
      exp_blank = (mode == M_EDIT) ? 4'(ph << sel) : (mode == M_DONE && ph == 1) ? 4'hF : 4'h0;
      chk("digits", digits, {4'(d[3]), 4'(d[2]), 4'(d[1]), 4'(d[0])});
      chk("sel_digit", 16'(sel_digit), 16'(sel));
      chk("blank", 16'(blank), 16'(exp_blank));
      chk("running", 16'(running), 16'(mode == M_RUN));
      chk("expired", 16'(expired), 16'(mode == M_DONE));
   endtask
   task automatic step(input bit r, input bit s, input bit i, input bit g, input bit t);
      rst = r; sel_pulse = s; inc_pulse = i; go_pulse = g; tick_1hz = t;
      @(posedge clk);
      model(r, s, i, g, t);
      #1;
      rst = 0; sel_pulse = 0; inc_pulse = 0; go_pulse = 0; tick_1hz = 0;
      check_all();
   endtask
   task automatic rep(input bit s, input bit i, input bit g, input bit t, input int n);
      for (int k = 0; k < n; k++) step(0, s, i, g, t);
   endtask
   initial begin
      int s10_seq[6] = '{1, 2, 3, 4, 5, 0};
      step(1, 0, 0, 0, 0);
      chk("rst_digits", digits, 16'h0000);
      // Build 03:27, run it, then reset with every pulse asserted.
      rep(0, 1, 0, 0, 7);
      step(0, 1, 0, 0, 0);
      rep(0, 1, 0, 0, 2);
      step(0, 1, 0, 0, 0);
      rep(0, 1, 0, 0, 3);
      chk("set_0327", digits, 16'h0327);
      step(0, 0, 0, 1, 0);
      chk("run_0327", 16'(running), 16'd1);
      step(1, 1, 1, 1, 1);
      chk("rst_mid_run_digits", digits, 16'h0000);
      chk("rst_mid_run_running", 16'(running), 16'd0);
      chk("rst_mid_run_sel", 16'(sel_digit), 16'd0);
      step(0, 1, 0, 0, 0);
      foreach (s10_seq[k]) begin
         step(0, 0, 1, 0, 0);
         chk("s10_seq", 16'(digits[7:4]), 16'(s10_seq[k]));
      end
      chk("s10_others", digits, 16'h0000);
      // 01:00 counted down to expiry.
      step(0, 1, 0, 0, 0);
      step(0, 0, 1, 0, 0);
      step(0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 1);
      chk("first_tick", digits, 16'h0059);
      chk("first_tick_run", 16'(running), 16'd1);
      rep(0, 0, 0, 1, 58);
      chk("before_last", 16'(expired), 16'd0);
      step(0, 0, 0, 0, 1);
      chk("expired_edge", 16'(expired), 16'd1);
      chk("expired_digits", digits, 16'h0000);
      rep(0, 0, 0, 0, 9);
      step(0, 0, 0, 1, 0);
      chk("done_ack_sel", 16'(sel_digit), 16'd0);
      chk("done_ack_exp", 16'(expired), 16'd0);
      step(0, 0, 0, 1, 0);
      chk("zero_go_ignored", 16'(running), 16'd0);
      // 00:05 with a coincident go and tick.
      rep(0, 1, 0, 0, 5);
      step(0, 0, 0, 1, 0);
      step(0, 0, 0, 1, 1);
      chk("go_tick_digits", digits, 16'h0004);
      chk("go_tick_paused", 16'(running), 16'd0);
      rep(0, 0, 0, 1, 3);
      chk("pause_frozen", digits, 16'h0004);
      step(0, 0, 0, 1, 0);
      chk("resume", 16'(running), 16'd1);
      // Pause, back to edit, observe blink and selection clearing it.
      step(0, 0, 0, 1, 0);
      step(0, 1, 0, 0, 0);
      rep(0, 0, 0, 0, 13);
      step(0, 1, 0, 0, 0);
      chk("sel_clears_blank", 16'(blank), 16'd0);
      rep(0, 0, 0, 0, 6);
      step(0, 0, 0, 1, 0);
      chk("run_blank", 16'(blank), 16'd0);
      for (int k = 0; k < 4000; k++)
         step($urandom_range(0, 499) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0,
              $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/clock_set_controller.md
Name: clock_set_controller

Overview:
- Mode controller for the countdown clock display.
- Owns the 4-digit MM:SS BCD time value and sequences it through edit, run, pause and expired modes.
- Consumes debounced single-cycle button pulses: select-digit, increment-digit and start/stop, plus a 1 Hz tick pulse.
- Drives the BCD digits, the selected-digit index and a per-digit blank mask to the 7-segment display mux.

Parameters:
BLINK_DIV, 25_000_000, clk cycles per blink half-period for the selected digit in EDIT.
BLINK_W, 25, width of the blink counter; must satisfy 2^BLINK_W > BLINK_DIV.

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
tick_1hz  input  1  one-cycle pulse once per second
sel_pulse  input  1  debounced one-cycle pulse: advance selected digit
inc_pulse  input  1  debounced one-cycle pulse: increment selected digit
go_pulse  input  1  debounced one-cycle pulse: start/pause/resume/acknowledge
digits  output  16  {M10,M1,S10,S1}, BCD, digit 0 = [3:0] = S1
sel_digit  output  2  currently selected digit index, 0 = S1, 3 = M10
blank  output  4  per-digit blank (1 = segments off)
running  output  1  high in RUN
expired  output  1  high in DONE

Behaviour:
- Reset takes effect on the clk edge where rst = 1 and overrides all inputs:
  - state = EDIT, digits = 16'h0000, sel_digit = 0, blank = 0, running = 0, expired = 0.
  - Blink counter and blink phase are cleared.
- States: EDIT, RUN, PAUSE, DONE.
- EDIT:
  - sel_pulse: sel_digit increments mod 4 (3 -> 0).
  - inc_pulse: the selected digit increments with wrap.
    - S1 and M1 wrap 9 -> 0.
    - S10 and M10 wrap 5 -> 0.
    - There is no carry into neighbouring digits.
  - go_pulse with digits != 0: go to RUN. With digits == 0, go_pulse is ignored.
  - Blink: counter counts to BLINK_DIV-1, then toggles blink phase.
    - blank[sel_digit] = blink phase. All other blank bits are 0.
    - The counter and phase reset to 0 on any sel_pulse, so a newly selected digit is visible immediately.
- RUN:
  - running = 1, blank = 0.
  - On tick_1hz the value decrements by one second, BCD-correct.
    - S1 borrows from S10, S10 borrows from M1 (S10 reloads 5, S1 reloads 9), M1 borrows from M10.
    - Example: 10:00 -> 09:59.
  - When a tick decrements 00:01 -> 00:00, go to DONE on that same edge.
  - go_pulse -> PAUSE.
  - sel_pulse and inc_pulse are ignored.
- PAUSE:
  - Value frozen, blank = 0.
  - go_pulse -> RUN.
  - sel_pulse -> EDIT with the value retained and sel_digit retained.
  - Ticks are ignored.
- DONE:
  - expired = 1, digits = 0.
  - blank = 4'b1111 when blink phase = 1 (whole display flashes at the blink rate).
  - go_pulse -> EDIT with digits = 0, sel_digit = 0.
- Simultaneous events:
  - In RUN, go_pulse and tick_1hz in the same cycle: the tick decrement applies and the state goes to PAUSE. If that decrement reaches 00:00, DONE wins.
  - In EDIT, sel_pulse and inc_pulse in the same cycle: inc applies to the old sel_digit, then the selection advances.
- Latency: all outputs are registered; every effect is visible the cycle after the causing pulse.
- Outputs are a function of registered state only; there are no combinational input-to-output paths.

Decomposition:
- Shared package holds:
  - State encoding constants: ST_EDIT = 2'd0, ST_RUN = 2'd1, ST_PAUSE = 2'd2, ST_DONE = 2'd3.
  - Digit index constants: D_S1 = 0, D_S10 = 1, D_M1 = 2, D_M10 = 3.
  - Digit wrap limits: 9, 5, 9, 5.
- One sub-module, mmss_bcd_decrement:
  - Combinational: 16-bit BCD in, decremented BCD out, plus an is_zero_next flag.
  - Reused by the FSM in RUN.

Test Plan:
- Reset mid-RUN at 03:27 -> next cycle digits = 0000, state EDIT, sel_digit = 0, running = 0.
- EDIT, sel_digit = 1 (S10), 6 × inc_pulse -> S10 sequence 1,2,3,4,5,0; other digits unchanged.
- Set 01:00, go_pulse, 1 tick -> digits = 0059, running = 1; 59 further ticks -> 0000, expired = 1 on the same edge as the last tick.
- RUN at 00:05, go_pulse coincident with tick -> digits = 0004, state PAUSE; 3 ticks -> still 0004; go_pulse -> RUN.
- EDIT, digits = 0000, go_pulse -> stays EDIT, running = 0. DONE then go_pulse -> EDIT, sel_digit = 0.
- BLINK_DIV = 4 in sim, EDIT: blank[sel_digit] toggles every 4 cycles; sel_pulse clears the phase so blank = 0 on the next cycle; RUN forces blank = 0.
